flappy_physics: RTL and testbench
=================================

// Module: flappy_physics
// PURPOSE
//  Motion engine that drives the Game FSM's position inputs (XBird, YBird, XPipe1/2, YPipe1/2).
//  Consumes the FSM state (q_I, q_EN, q_End) and the player Flap button.
//  Advances bird gravity/flap and pipe scrolling once per frame tick; respawns pipes with new gap heights.
//  Sits between the button debouncer, Game and the VGA renderer.
// PARAMETERS
//  FRAME_DIV     833333  Clk cycles per frame tick (60 Hz at 50 MHz)
//  BIRD_X        200     fixed bird X (px)
//  BIRD_Y0       240     bird Y in q_I
//  FLOOR_Y       470     max bird Y
//  GRAVITY       1       velocity increment per frame (px/frame)
//  FLAP_V        8       upward speed set by a flap (px/frame)
//  VMAX          10      max downward velocity
//  PIPE_SPEED    2       pipe X decrement per frame
//  PIPE_X0       640     XPipe1 in q_I; XPipe2 = PIPE_X0+PIPE_SPACING
//  PIPE_SPACING  320     X distance between pipes; respawn adds 2*PIPE_SPACING
// PORTS
//  Clk     in   1   system clock, all logic on posedge
//  Reset   in   1   synchronous, active-high reset
//  Flap    in   1   debounced flap button, level
//  q_I     in   1   Game FSM idle state
//  q_EN    in   1   Game FSM play state
//  q_End   in   1   Game FSM end state
//  XBird   out  10  bird X (always BIRD_X)
//  YBird   out  10  bird Y, top of screen = 0
//  XPipe1  out  10  pipe 1 centre X
//  YPipe1  out  10  pipe 1 gap top Y (gap is 150 px tall)
//  XPipe2  out  10  pipe 2 centre X
//  YPipe2  out  10  pipe 2 gap top Y
//  Frame   out  1   one-cycle pulse on each frame tick
// BEHAVIOUR
//  Reset: YBird=BIRD_Y0, vel=0, XPipe1=PIPE_X0, XPipe2=PIPE_X0+PIPE_SPACING, YPipe1=120, YPipe2=200.
//   Also: Frame=0, frame counter=0, flap latch=0, LFSR=16'hACE1, table index=0.
//  Frame counter: counts 0..FRAME_DIV-1 and wraps. Frame=1 in the cycle the count wraps; position updates take effect at that same edge.
//  Mode priority: q_End > q_EN > q_I; all inputs low = hold everything.
//  q_I: all outputs forced to their reset values every cycle. Flap latch cleared.
//  q_EN: Flap rising edge (registered compare) sets the flap latch; the latch clears on the frame tick that consumes it.
//   Per tick: vel (signed 8b) = latch ? -FLAP_V : min(vel+GRAVITY, VMAX). Flap wins over floor/ceiling.
//   Per tick: ny = YBird + vel, computed in 11-bit signed.
//   ny<0 -> YBird=0, vel=0. ny>FLOOR_Y -> YBird=FLOOR_Y, vel=0. Otherwise YBird=ny.
//   Per tick, each pipe: if XPipe < PIPE_SPEED then XPipe += 2*PIPE_SPACING-PIPE_SPEED and YPipe = new gap.
//   Otherwise XPipe -= PIPE_SPEED. Never wraps through 0.
//   Both pipes respawning on the same tick is impossible by spacing. If it occurs, pipe1 takes the gap value, pipe2 takes the next.
//  q_End: all positions and vel frozen; Flap ignored; Frame keeps pulsing.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, steps every Clk in all modes. Never zero.
//  Reset asserted mid-frame: counter restarts at 0; no partial update is applied.
//  Gap range: 40..295, so gap bottom is <= 445.
// CONFIGURATION
//  FLAPPY_RANDOM_GAP_EN defined: new gap = 40 + LFSR[7:0].
//  Undefined: new gap = table {80,160,240,120}[idx]; idx (2b) increments per respawn and wraps 3->0. LFSR is not built.
// TESTING (bench uses FRAME_DIV=4, defaults otherwise)
//  Reset high 2 cycles, q_I=1 -> YBird=240, XPipe1=640, XPipe2=960, YPipe1=120, YPipe2=200, Frame=0.
//  q_EN, no flap, 5 ticks -> vel 1,2,3,4,5; YBird 241,243,246,250,255.
//  q_EN, flap pulse before tick 1 -> YBird 232, then 225 after tick 2 (vel -7).
//  q_EN, no flap, from YBird=465 with vel=10 -> YBird=470 and vel=0 held over 3 more ticks.
//  Ceiling: repeated flaps from YBird=5 -> YBird=0 and vel=0 after the clamp tick.
//  XPipe1=1 on a tick -> XPipe1=639. With the macro undefined, YPipe1=80, then 160 on the next respawn.
//  q_End after 10 ticks -> all outputs unchanged for 20 ticks despite Flap toggling. Frame still pulses every 4 cycles.
//  q_I reasserted -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/flappy_physics_if.sv
// Game FSM state, flap button and position/frame outputs of the flappy_physics motion engine.
interface flappy_physics_if;
    localparam int unsigned PW = 10;

    logic          Flap;
    logic          q_I;
    logic          q_EN;
    logic          q_End;
    logic [PW-1:0] XBird;
    logic [PW-1:0] YBird;
    logic [PW-1:0] XPipe1;
    logic [PW-1:0] YPipe1;
    logic [PW-1:0] XPipe2;
    logic [PW-1:0] YPipe2;
    logic          Frame;

    modport master (
        output Flap, q_I, q_EN, q_End,
        input  XBird, YBird, XPipe1, YPipe1, XPipe2, YPipe2, Frame
    );

    modport slave (
        input  Flap, q_I, q_EN, q_End,
        output XBird, YBird, XPipe1, YPipe1, XPipe2, YPipe2, Frame
    );
endinterface

// File: rtl/flappy_physics.sv
// Bird gravity/flap and pipe scrolling engine, updated once per frame tick.
// FLAPPY_RANDOM_GAP_EN: new pipe gaps come from a 16-bit LFSR instead of a fixed table.
module flappy_physics #(
    parameter int unsigned FRAME_DIV    = 833333,
    parameter int unsigned BIRD_X       = 200,
    parameter int unsigned BIRD_Y0      = 240,
    parameter int unsigned FLOOR_Y      = 470,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned FLAP_V       = 8,
    parameter int unsigned VMAX         = 10,
    parameter int unsigned PIPE_SPEED   = 2,
    parameter int unsigned PIPE_X0      = 640,
    parameter int unsigned PIPE_SPACING = 320
) (
    input  logic             Clk,
    input  logic             Reset,
    flappy_physics_if.slave  bus
);
    localparam int unsigned PW       = 10;
    localparam int unsigned VW       = 8;
    localparam int unsigned NW       = 11;
    localparam int unsigned CW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned PIPE_Y1  = 120;
    localparam int unsigned PIPE_Y2  = 200;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 frame, frame_nxt;
    logic                 latch, latch_nxt;
    logic                 flap_q;
    logic signed [VW-1:0] vel, vel_nxt;
    logic [PW-1:0]        ybird, ybird_nxt;
    logic [PW-1:0]        x1, x1_nxt, x2, x2_nxt;
    logic [PW-1:0]        y1, y1_nxt, y2, y2_nxt;

    logic                 tick, rise, fire, resp1, resp2;
    logic signed [VW-1:0] vel_up, vel_t;
    logic signed [NW-1:0] ny;
    logic [PW-1:0]        gap_a, gap_b;

`ifdef FLAPPY_RANDOM_GAP_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every mode
    always_ff @(posedge Clk) begin
        if (Reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign gap_a = PW'(40) + PW'(lfsr[7:0]);
    assign gap_b = PW'(40) + PW'(lfsr[15:8]);
`else
    logic [1:0] idx, idx_nxt;

    function automatic logic [PW-1:0] gap_tbl(input logic [1:0] i);
        case (i)
            2'd0:    gap_tbl = PW'(80);
            2'd1:    gap_tbl = PW'(160);
            2'd2:    gap_tbl = PW'(240);
            default: gap_tbl = PW'(120);
        endcase
    endfunction

    assign gap_a = gap_tbl(idx);
    assign gap_b = gap_tbl(idx + 2'd1);
`endif

    assign tick = (cnt == CNT_LAST);
    assign rise = bus.Flap & ~flap_q;
    assign fire = latch | rise;

    // Bird velocity and candidate position for this tick
    always_comb begin
        vel_up = vel + $signed(VW'(GRAVITY));
        if (vel_up > $signed(VW'(VMAX))) vel_up = $signed(VW'(VMAX));
        vel_t = fire ? -$signed(VW'(FLAP_V)) : vel_up;
        ny    = $signed({1'b0, ybird}) + $signed({{(NW-VW){vel_t[VW-1]}}, vel_t});
    end

    assign resp1 = (x1 < PW'(PIPE_SPEED));
    assign resp2 = (x2 < PW'(PIPE_SPEED));

    always_comb begin
        cnt_nxt   = cnt;
        frame_nxt = 1'b0;
        latch_nxt = latch;
        vel_nxt   = vel;
        ybird_nxt = ybird;
        x1_nxt    = x1;
        x2_nxt    = x2;
        y1_nxt    = y1;
        y2_nxt    = y2;
`ifndef FLAPPY_RANDOM_GAP_EN
        idx_nxt   = idx;
`endif
        if (bus.q_End) begin
            cnt_nxt   = tick ? '0 : cnt + CW'(1);
            frame_nxt = tick;
        end else if (bus.q_EN) begin
            cnt_nxt   = tick ? '0 : cnt + CW'(1);
            frame_nxt = tick;
            if (tick) begin
                latch_nxt = 1'b0;
                if (ny[NW-1]) begin
                    ybird_nxt = '0;
                    vel_nxt   = '0;
                end else if (ny > $signed(NW'(FLOOR_Y))) begin
                    ybird_nxt = PW'(FLOOR_Y);
                    vel_nxt   = '0;
                end else begin
                    ybird_nxt = ny[PW-1:0];
                    vel_nxt   = vel_t;
                end
                x1_nxt = resp1 ? x1 + PW'(2*PIPE_SPACING - PIPE_SPEED) : x1 - PW'(PIPE_SPEED);
                x2_nxt = resp2 ? x2 + PW'(2*PIPE_SPACING - PIPE_SPEED) : x2 - PW'(PIPE_SPEED);
                // A second simultaneous respawn takes the following gap value
                if (resp1) y1_nxt = gap_a;
                if (resp2) y2_nxt = resp1 ? gap_b : gap_a;
`ifndef FLAPPY_RANDOM_GAP_EN
                idx_nxt = idx + 2'(resp1) + 2'(resp2);
`endif
            end else if (rise) begin
                latch_nxt = 1'b1;
            end
        end else if (bus.q_I) begin
            cnt_nxt   = '0;
            latch_nxt = 1'b0;
            vel_nxt   = '0;
            ybird_nxt = PW'(BIRD_Y0);
            x1_nxt    = PW'(PIPE_X0);
            x2_nxt    = PW'(PIPE_X0 + PIPE_SPACING);
            y1_nxt    = PW'(PIPE_Y1);
            y2_nxt    = PW'(PIPE_Y2);
`ifndef FLAPPY_RANDOM_GAP_EN
            idx_nxt   = '0;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt    <= '0;
            frame  <= 1'b0;
            latch  <= 1'b0;
            flap_q <= 1'b0;
            vel    <= '0;
            ybird  <= PW'(BIRD_Y0);
            x1     <= PW'(PIPE_X0);
            x2     <= PW'(PIPE_X0 + PIPE_SPACING);
            y1     <= PW'(PIPE_Y1);
            y2     <= PW'(PIPE_Y2);
`ifndef FLAPPY_RANDOM_GAP_EN
            idx    <= '0;
`endif
        end else begin
            cnt    <= cnt_nxt;
            frame  <= frame_nxt;
            latch  <= latch_nxt;
            flap_q <= bus.Flap;
            vel    <= vel_nxt;
            ybird  <= ybird_nxt;
            x1     <= x1_nxt;
            x2     <= x2_nxt;
            y1     <= y1_nxt;
            y2     <= y2_nxt;
`ifndef FLAPPY_RANDOM_GAP_EN
            idx    <= idx_nxt;
`endif
        end
    end

    assign bus.XBird  = PW'(BIRD_X);
    assign bus.YBird  = ybird;
    assign bus.XPipe1 = x1;
    assign bus.YPipe1 = y1;
    assign bus.XPipe2 = x2;
    assign bus.YPipe2 = y2;
    assign bus.Frame  = frame;
endmodule

// File: tb/tb_flappy_physics.sv
// Bench for flappy_physics: directed table, corner sequences and random play against a frame-level model.
module tb_flappy_physics;
    localparam int DIV = 4;

    logic clk;
    logic rst;
    flappy_physics_if bus ();

    flappy_physics #(.FRAME_DIV(DIV)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state, in plain integers
    int m_y, m_v, m_x1, m_x2, m_g1, m_g2, m_idx, m_cnt;
    bit m_frame, m_latch, m_fprev;
    bit [15:0] m_lfsr;
    int gap_table[4] = '{80, 160, 240, 120};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_positions_reset();
        m_y = 240; m_v = 0; m_x1 = 640; m_x2 = 960; m_g1 = 120; m_g2 = 200;
        m_idx = 0; m_cnt = 0; m_frame = 0; m_latch = 0;
    endtask

    function automatic int new_gap(input int k, input bit [15:0] l);
`ifdef FLAPPY_RANDOM_GAP_EN
        return 40 + int'(l[k*8 +: 8]);
`else
        return gap_table[(m_idx + k) % 4];
`endif
    endfunction

    // One clock edge worth of game rules
    task automatic model_step();
        bit [15:0] l;
        bit rise, tick, r1, r2;
        int ny, k;
        l = m_lfsr;
        if (rst) begin
            model_positions_reset();
            m_fprev = 0;
            m_lfsr = 16'hACE1;
            return;
        end
        m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        rise = bus.Flap && !m_fprev;
        m_fprev = bus.Flap;
        tick = (m_cnt == DIV - 1);
        if (bus.q_End) begin
            m_cnt = tick ? 0 : m_cnt + 1;
            m_frame = tick;
        end else if (bus.q_EN) begin
            m_cnt = tick ? 0 : m_cnt + 1;
            m_frame = tick;
            if (tick) begin
                m_v = (m_latch || rise) ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
                m_latch = 0;
                ny = m_y + m_v;
                if (ny < 0) begin m_y = 0; m_v = 0; end
                else if (ny > 470) begin m_y = 470; m_v = 0; end
                else m_y = ny;
                r1 = m_x1 < 2;
                r2 = m_x2 < 2;
                k = 0;
                if (r1) begin m_x1 += 638; m_g1 = new_gap(k, l); k++; end
                else m_x1 -= 2;
                if (r2) begin m_x2 += 638; m_g2 = new_gap(k, l); k++; end
                else m_x2 -= 2;
                m_idx = (m_idx + k) % 4;
            end else if (rise) begin
                m_latch = 1;
            end
        end else if (bus.q_I) begin
            model_positions_reset();
        end else begin
            m_frame = 0;
        end
    endtask

    task automatic check_model();
        chk("XBird",  int'(bus.XBird),  200);
        chk("YBird",  int'(bus.YBird),  m_y);
        chk("XPipe1", int'(bus.XPipe1), m_x1);
        chk("YPipe1", int'(bus.YPipe1), m_g1);
        chk("XPipe2", int'(bus.XPipe2), m_x2);
        chk("YPipe2", int'(bus.YPipe2), m_g2);
        chk("Frame",  int'(bus.Frame),  int'(m_frame));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin cycle(); n++; end while (!m_frame && n < 2 * DIV + 2);
        if (!m_frame) chk("tick_timeout", 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_YBird"},  int'(bus.YBird),  240);
        chk({tag, "_XPipe1"}, int'(bus.XPipe1), 640);
        chk({tag, "_XPipe2"}, int'(bus.XPipe2), 960);
        chk({tag, "_YPipe1"}, int'(bus.YPipe1), 120);
        chk({tag, "_YPipe2"}, int'(bus.YPipe2), 200);
        chk({tag, "_Frame"},  int'(bus.Frame),  0);
    endtask

    typedef struct {
        bit flap;
        int y;
        int x1;
    } row_t;

    initial begin
        row_t rows[7];
        int snap_y, snap_x1, snap_x2, snap_g1, snap_g2, frames, n, prev;
        bit done;

        rows[0] = '{0, 241, 638};
        rows[1] = '{0, 243, 636};
        rows[2] = '{0, 246, 634};
        rows[3] = '{0, 250, 632};
        rows[4] = '{0, 255, 630};
        rows[5] = '{1, 247, 628};
        rows[6] = '{0, 240, 626};

        m_fprev = 0; m_lfsr = 16'hACE1; model_positions_reset();
        rst = 1'b1; bus.Flap = 1'b0; bus.q_I = 1'b1; bus.q_EN = 1'b0; bus.q_End = 1'b0;
        cycle(); cycle();
        check_reset_values("reset");
        rst = 1'b0;
        cycle();

        // Free fall then one flap, one frame per row
        bus.q_I = 1'b0; bus.q_EN = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (rows[i].flap) begin
                bus.Flap = 1'b1; cycle(); bus.Flap = 1'b0;
            end
            wait_tick();
            chk($sformatf("row%0d_YBird", i), int'(bus.YBird), rows[i].y);
            chk($sformatf("row%0d_XPipe1", i), int'(bus.XPipe1), rows[i].x1);
        end

        // Floor clamp
        n = 0;
        while (m_y != 470 && n < 100) begin wait_tick(); n++; end
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            chk("floor_hold", int'(bus.YBird), 470);
        end

        // Ceiling clamp, then confirm velocity was zeroed
        n = 0;
        while (m_y != 0 && n < 100) begin
            bus.Flap = 1'b1; cycle(); bus.Flap = 1'b0;
            wait_tick(); n++;
        end
        chk("ceiling_y", int'(bus.YBird), 0);
        wait_tick();
        chk("ceiling_vel0", int'(bus.YBird), 1);

        // Pipe respawns through zero
        done = 0; n = 0;
        while (!done && n < 400) begin
            prev = m_x1; wait_tick(); n++;
            done = (m_x1 > prev);
        end
        chk("resp1_x", int'(bus.XPipe1), 638);
`ifndef FLAPPY_RANDOM_GAP_EN
        chk("resp1_gap", int'(bus.YPipe1), 80);
`endif
        done = 0; n = 0;
        while (!done && n < 400) begin
            prev = m_x2; wait_tick(); n++;
            done = (m_x2 > prev);
        end
        chk("resp2_x", int'(bus.XPipe2), 638);
`ifndef FLAPPY_RANDOM_GAP_EN
        chk("resp2_gap", int'(bus.YPipe2), 160);
`endif

        // End state: frozen positions, Frame still pulsing
        snap_y = m_y; snap_x1 = m_x1; snap_x2 = m_x2; snap_g1 = m_g1; snap_g2 = m_g2;
        bus.q_End = 1'b1;
        frames = 0;
        for (int i = 0; i < 20 * DIV; i++) begin
            bus.Flap = ~bus.Flap;
            cycle();
            if (bus.Frame) frames++;
        end
        bus.Flap = 1'b0;
        chk("end_frames", frames, 20);
        chk("end_YBird",  int'(bus.YBird),  snap_y);
        chk("end_XPipe1", int'(bus.XPipe1), snap_x1);
        chk("end_XPipe2", int'(bus.XPipe2), snap_x2);
        chk("end_YPipe1", int'(bus.YPipe1), snap_g1);
        chk("end_YPipe2", int'(bus.YPipe2), snap_g2);

        bus.q_End = 1'b0; bus.q_EN = 1'b0; bus.q_I = 1'b1;
        cycle();
        check_reset_values("idle");

        // Random play with mode changes, overlapping mode inputs and mid-frame resets
        for (int i = 0; i < 4000; i++) begin
            int r;
            if ($urandom_range(0, 59) == 0) begin
                r = $urandom_range(0, 9);
                bus.q_End = (r >= 8);
                bus.q_EN  = (r >= 2 && r <= 7) || (r >= 8 && $urandom_range(0, 1) == 1);
                bus.q_I   = (r == 1) || (r >= 2 && $urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            bus.Flap = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
